// File: rtl/lap_stopwatch.sv
// BCD stopwatch (sec/min/hour/day) with run/stop toggle and a show-ahead lap-capture FIFO.
// Reset is synchronous and active-low; en=0 holds the block cleared and idle.
module lap_stopwatch #(
  parameter int unsigned CNT_W     = 10,
  parameter int unsigned TICK_DIV  = 999,
  parameter int unsigned DBG_DIV   = 9,
  parameter int unsigned DAY_MAX   = 31,
  parameter int unsigned LAP_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         en,
  input  logic                         dbg,
  input  logic                         start,
  input  logic                         lap,
  input  logic                         lap_rd,
  output logic [3:0]                   sec0,
  output logic [3:0]                   sec1,
  output logic [3:0]                   min0,
  output logic [3:0]                   min1,
  output logic [3:0]                   hour0,
  output logic [3:0]                   hour1,
  output logic [3:0]                   day0,
  output logic [3:0]                   day1,
  output logic                         running,
  output logic                         lap_valid,
  output logic [31:0]                  lap_data,
  output logic [$clog2(LAP_DEPTH):0]   lap_count,
  output logic                         lap_ovf
);

  localparam int unsigned AW = $clog2(LAP_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [31:0] TimeRst = 32'h0100_0000;
  localparam logic [7:0]  DayMax  = {4'(DAY_MAX / 10), 4'(DAY_MAX % 10)};

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       time_q, time_d;
  logic              prev_start_q, prev_lap_q;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [31:0]       mem_q [LAP_DEPTH];

  logic              start_e, lap_e, is_run, tick;
  logic [CNT_W-1:0]  div;
  logic              fifo_empty, fifo_full, push_req, do_push, do_pop;

  // Whole-time increment with the full carry chain resolved in one cycle.
  function automatic logic [31:0] time_inc(input logic [31:0] t);
    logic [3:0] s0, s1, m0, m1, h0, h1, d0, d1;
    {d1, d0, h1, h0, m1, m0, s1, s0} = t;
    if (s0 != 4'd9) begin
      s0 = s0 + 4'd1;
    end else begin
      s0 = 4'd0;
      if (s1 != 4'd5) begin
        s1 = s1 + 4'd1;
      end else begin
        s1 = 4'd0;
        if (m0 != 4'd9) begin
          m0 = m0 + 4'd1;
        end else begin
          m0 = 4'd0;
          if (m1 != 4'd5) begin
            m1 = m1 + 4'd1;
          end else begin
            m1 = 4'd0;
            if ({h1, h0} == 8'h23) begin
              {h1, h0} = 8'h00;
              if ({d1, d0} == DayMax) begin
                {d1, d0} = 8'h01;
              end else if (d0 != 4'd9) begin
                d0 = d0 + 4'd1;
              end else begin
                d0 = 4'd0;
                d1 = d1 + 4'd1;
              end
            end else if (h0 != 4'd9) begin
              h0 = h0 + 4'd1;
            end else begin
              h0 = 4'd0;
              h1 = h1 + 4'd1;
            end
          end
        end
      end
    end
    return {d1, d0, h1, h0, m1, m0, s1, s0};
  endfunction

  always_comb begin
    start_e = start & ~prev_start_q;
    lap_e   = lap & ~prev_lap_q;
    is_run  = (state_q == StRun);
    div     = dbg ? CNT_W'(DBG_DIV) : CNT_W'(TICK_DIV);
    tick    = is_run && (cnt_q == div);

    state_d = state_q;
    cnt_d   = cnt_q;
    time_d  = time_q;
    if (!en) begin
      state_d = StIdle;
      cnt_d   = '0;
      time_d  = TimeRst;
    end else begin
      if (start_e) state_d = is_run ? StIdle : StRun;
      // State is sampled before the toggle, so a tick on the stopping edge still lands.
      if (is_run) begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        if (tick) time_d = time_inc(time_q);
      end
    end
  end

  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CW'(LAP_DEPTH));
    push_req   = en && lap_e && is_run;
    do_pop     = en && lap_rd && !fifo_empty;
    do_push    = push_req && (!fifo_full || do_pop);

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (!en) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (do_pop && !do_push) count_d = count_q - CW'(1);
      if (push_req && !do_push) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      time_q       <= TimeRst;
      prev_start_q <= 1'b0;
      prev_lap_q   <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      time_q       <= time_d;
      prev_start_q <= start;
      prev_lap_q   <= lap;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
    end
  end

  // Storage needs no reset: the head is gated to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= time_q;
  end

  assign {day1, day0, hour1, hour0, min1, min0, sec1, sec0} = time_q;
  assign running   = is_run;
  assign lap_valid = !fifo_empty;
  assign lap_data  = fifo_empty ? 32'h0 : mem_q[rd_ptr_q];
  assign lap_count = count_q;
  assign lap_ovf   = ovf_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Directed bench for lap_stopwatch: time expectations from a seconds-to-BCD model,
// lap snapshots checked through an expected-value queue.
module tb_lap_stopwatch;

  localparam int unsigned DayMaxTb = 31;
  localparam int unsigned Depth    = 4;

  logic        clk = 1'b0;
  logic        rstn, en, dbg, start, lap, lap_rd;
  logic [3:0]  sec0, sec1, min0, min1, hour0, hour1, day0, day1;
  logic        running, lap_valid, lap_ovf;
  logic [31:0] lap_data;
  logic [2:0]  lap_count;
  logic [31:0] disp;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q [$];
  int exp_count = 0;
  logic exp_ovf = 1'b0;

  lap_stopwatch dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .dbg       (dbg),
    .start     (start),
    .lap       (lap),
    .lap_rd    (lap_rd),
    .sec0      (sec0),
    .sec1      (sec1),
    .min0      (min0),
    .min1      (min1),
    .hour0     (hour0),
    .hour1     (hour1),
    .day0      (day0),
    .day1      (day1),
    .running   (running),
    .lap_valid (lap_valid),
    .lap_data  (lap_data),
    .lap_count (lap_count),
    .lap_ovf   (lap_ovf)
  );

  always #5 clk = ~clk;

  assign disp = {day1, day0, hour1, hour0, min1, min0, sec1, sec0};

  function automatic logic [31:0] bcd_time(input int unsigned s);
    int unsigned d, h, m, x;
    d = 1 + (s / 86400) % DayMaxTb;
    h = (s / 3600) % 24;
    m = (s / 60) % 60;
    x = s % 60;
    return {4'(d / 10), 4'(d % 10), 4'(h / 10), 4'(h % 10),
            4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Expect a push of the current time unless the model says the FIFO is full.
  task automatic pulse_lap(input logic [31:0] snap);
    if (exp_count < Depth) begin
      exp_q.push_back(snap);
      exp_count++;
    end else begin
      exp_ovf = 1'b1;
    end
    lap = 1'b1;
    @(negedge clk);
    lap = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_time"}, disp, 32'h0100_0000);
    check({tag, "_running"}, 32'(running), 32'd0);
    check({tag, "_count"}, 32'(lap_count), 32'd0);
    check({tag, "_valid"}, 32'(lap_valid), 32'd0);
    check({tag, "_ovf"}, 32'(lap_ovf), 32'd0);
  endtask

  task automatic preload(input logic [31:0] t);
    force dut.time_q = t;
    @(negedge clk);
    release dut.time_q;
  endtask

  initial begin
    rstn = 1'b0; en = 1'b1; dbg = 1'b1; start = 1'b0; lap = 1'b0; lap_rd = 1'b0;
    cyc(2);
    rstn = 1'b1;
    check_reset_state("reset");
    check("reset_data", lap_data, 32'h0);

    // 600 debug ticks from a fresh start
    pulse_start();
    cyc(6000);
    check("run_10min", disp, bcd_time(600));
    check("run_running", 32'(running), 32'd1);

    pulse_start();
    check("stop_running", 32'(running), 32'd0);
    cyc(50);
    check("stop_frozen", disp, bcd_time(600));

    lap = 1'b1; cyc(1); lap = 1'b0; cyc(1);
    check("idle_lap_count", 32'(lap_count), 32'd0);
    check("idle_lap_valid", 32'(lap_valid), 32'd0);

    // Restart: prescaler fraction (1) was kept, so the next tick comes after 9 edges
    pulse_start();
    cyc(8);
    check("frac_before", disp, bcd_time(600));
    cyc(1);
    check("frac_tick", disp, bcd_time(601));

    // Five laps one second apart; the fifth is dropped
    for (int i = 0; i < 5; i++) begin
      pulse_lap(bcd_time(601 + i));
      cyc(9);
    end
    check("full_count", 32'(lap_count), 32'(exp_count));
    check("full_ovf", 32'(lap_ovf), 32'(exp_ovf));
    check("full_valid", 32'(lap_valid), 32'd1);
    check("full_time", disp, bcd_time(606));

    // Pop and lap together while full
    check("head0", lap_data, exp_q.pop_front());
    exp_q.push_back(bcd_time(606));
    lap = 1'b1; lap_rd = 1'b1;
    cyc(1);
    lap = 1'b0; lap_rd = 1'b0;
    check("pushpop_count", 32'(lap_count), 32'd4);
    cyc(7);
    check("head1", lap_data, exp_q.pop_front());
    exp_count = 3;
    lap_rd = 1'b1; cyc(1); lap_rd = 1'b0;
    check("pop_count", 32'(lap_count), 32'd3);

    // Lap on the tick edge captures the pre-tick time
    pulse_lap(bcd_time(606));
    check("tick_lap_time", disp, bcd_time(607));
    check("tick_lap_count", 32'(lap_count), 32'(exp_count));

    // START held high toggles only once
    start = 1'b1;
    cyc(5);
    check("held_start_running", 32'(running), 32'd0);
    start = 1'b0;
    cyc(1);
    check("held_start_still", 32'(running), 32'd0);
    check("held_start_time", disp, bcd_time(607));

    // Drain in order
    for (int i = 0; i < Depth; i++) begin
      if (exp_q.size() != 0) begin
        check("drain_valid", 32'(lap_valid), 32'd1);
        check("drain_data", lap_data, exp_q.pop_front());
        lap_rd = 1'b1;
        cyc(1);
      end
    end
    lap_rd = 1'b0;
    exp_count = 0;
    check("drain_empty_valid", 32'(lap_valid), 32'd0);
    check("drain_empty_data", lap_data, 32'h0);
    lap_rd = 1'b1; cyc(1); lap_rd = 1'b0;
    check("empty_rd_count", 32'(lap_count), 32'd0);
    check("ovf_sticky", 32'(lap_ovf), 32'd1);

    // en=0 mid-run with a lap stored
    pulse_start();
    pulse_lap(bcd_time(607));
    check("pre_en_data", lap_data, bcd_time(607));
    check("pre_en_count", 32'(lap_count), 32'd1);
    cyc(3);
    en = 1'b0;
    cyc(1);
    check_reset_state("en_off");
    en = 1'b1;
    exp_q.delete(); exp_count = 0; exp_ovf = 1'b0;

    // Reset mid-run with a lap stored
    pulse_start();
    cyc(25);
    pulse_lap(bcd_time(2));
    check("pre_rst_time", disp, bcd_time(2));
    check("pre_rst_count", 32'(lap_count), 32'd1);
    rstn = 1'b0;
    cyc(1);
    rstn = 1'b1;
    check_reset_state("rst_mid");
    exp_q.delete(); exp_count = 0;

    // Normal-mode divider: one tick per 1000 edges
    dbg = 1'b0;
    pulse_start();
    cyc(999);
    check("norm_before", disp, bcd_time(0));
    cyc(1);
    check("norm_tick", disp, bcd_time(1));
    en = 1'b0; cyc(1); en = 1'b1; dbg = 1'b1;

    // Full rollover from 23:59:59 on the last day
    preload(32'h3123_5959);
    check("preload", disp, 32'h3123_5959);
    pulse_start();
    cyc(9);
    check("roll_before", disp, 32'h3123_5959);
    cyc(1);
    check("roll_day", disp, 32'h0100_0000);
    check("roll_running", 32'(running), 32'd1);

    pulse_start();
    preload(32'h0923_5959);
    pulse_start();
    cyc(8);
    check("day9_before", disp, 32'h0923_5959);
    cyc(1);
    check("day9_to_10", disp, 32'h1000_0000);

    pulse_start();
    preload(32'h0509_5959);
    pulse_start();
    cyc(9);
    check("hour9_to_10", disp, 32'h0510_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
